// File: rtl/hdmi_island_scheduler_if.sv
// Signal bundle between the blanking timing/packet sources and the data-island scheduler.
// master = timing generator and packet requesters, slave = scheduler.
interface hdmi_island_scheduler_if #(
   parameter int NUM_SOURCES = 4
);
   logic [11:0]            blank_remaining;
   logic [NUM_SOURCES-1:0] req;
   logic [NUM_SOURCES-1:0] grant;
   logic                   pkt_start;
   logic [4:0]             pkt_index;
   logic [1:0]             mode;
   logic                   island_active;

   modport master (
      output blank_remaining, req,
      input  grant, pkt_start, pkt_index, mode, island_active
   );

   modport slave (
      input  blank_remaining, req,
      output grant, pkt_start, pkt_index, mode, island_active
   );
endinterface

// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island sequencer with round-robin packet-slot arbitration (clk_pixel domain).
// Optional HDMI_ISLAND_PRIO0_EN: source 0 wins every slot it requests; the others share round-robin.
module hdmi_island_scheduler #(
   parameter int NUM_SOURCES  = 4,
   parameter int MAX_PACKETS  = 18,
   parameter int VIDEO_LEADIN = 10,
   parameter int MIN_CTRL     = 4
) (
   input logic                    clk_pixel,
   input logic                    reset,
   hdmi_island_scheduler_if.slave bus
);
   localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
   localparam int GAP_W = $clog2(MIN_CTRL + 1);
   localparam logic [11:0]      START_MIN = 12'(44 + VIDEO_LEADIN);
   localparam logic [11:0]      CONT_MIN  = 12'(34 + VIDEO_LEADIN);
   localparam logic [GAP_W-1:0] GAP_DONE  = GAP_W'(MIN_CTRL);
   localparam logic [4:0]       PKT_LIMIT = 5'(MAX_PACKETS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_LEAD_GUARD,
      S_PACKET,
      S_TRAIL_GUARD
   } state_t;

   state_t                 state, state_next;
   logic [2:0]             phase, phase_next;
   logic [PTR_W-1:0]       rr_ptr, rr_ptr_next;
   logic [4:0]             sent, sent_next;
   logic [GAP_W-1:0]       gap, gap_next;
   logic [NUM_SOURCES-1:0] grant_q, grant_next;
   logic                   pkt_start_q, pkt_start_next;
   logic [4:0]             pkt_index_q, pkt_index_next;
   logic [1:0]             mode_q, mode_next;
   logic                   active_q;
   logic                   pick_valid;
   logic [PTR_W-1:0]       pick_idx;
   logic [PTR_W-1:0]       cand;
   logic                   ptr_take;
   logic                   take_grant;

`ifdef HDMI_ISLAND_PRIO0_EN
   // Source 0 bypasses the rotation and never moves the pointer, so the others keep their turn order.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      if (bus.req[0]) begin
         pick_valid = 1'b1;
      end else begin
         for (int i = 0; i < NUM_SOURCES - 1; i++) begin
            cand = PTR_W'(1 + (int'(rr_ptr) + i) % (NUM_SOURCES - 1));
            if (!pick_valid && bus.req[cand]) begin
               pick_valid = 1'b1;
               pick_idx   = cand;
            end
         end
      end
      ptr_take = (pick_idx != '0);
   end
`else
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         cand = PTR_W'((int'(rr_ptr) + 1 + i) % NUM_SOURCES);
         if (!pick_valid && bus.req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
      ptr_take = 1'b1;
   end
`endif

   always_comb begin
      state_next     = state;
      phase_next     = phase + 3'd1;
      rr_ptr_next    = rr_ptr;
      sent_next      = sent;
      gap_next       = gap;
      grant_next     = '0;
      pkt_start_next = 1'b0;
      pkt_index_next = '0;
      take_grant     = 1'b0;
      case (state)
         S_IDLE: begin
            phase_next = '0;
            sent_next  = '0;
            if (gap < GAP_DONE) gap_next = gap + GAP_W'(1);
            if (|bus.req && gap >= GAP_DONE && bus.blank_remaining >= START_MIN)
               state_next = S_PREAMBLE;
         end
         S_PREAMBLE: begin
            if (phase == 3'd7) begin
               state_next = S_LEAD_GUARD;
               phase_next = '0;
            end
         end
         S_LEAD_GUARD: begin
            if (phase == 3'd1) begin
               phase_next = '0;
               if (pick_valid) take_grant = 1'b1;
               else            state_next = S_TRAIL_GUARD;
            end
         end
         S_PACKET: begin
            grant_next     = grant_q;
            pkt_index_next = pkt_index_q + 5'd1;
            if (pkt_index_q == 5'd31) begin
               phase_next = '0;
               if (pick_valid && sent < PKT_LIMIT && bus.blank_remaining >= CONT_MIN) begin
                  take_grant = 1'b1;
               end else begin
                  state_next     = S_TRAIL_GUARD;
                  grant_next     = '0;
                  pkt_index_next = '0;
               end
            end
         end
         S_TRAIL_GUARD: begin
            if (phase == 3'd1) begin
               state_next = S_IDLE;
               phase_next = '0;
               gap_next   = '0;
            end
         end
         default: state_next = S_IDLE;
      endcase
      if (take_grant) begin
         state_next     = S_PACKET;
         grant_next     = NUM_SOURCES'(1) << pick_idx;
         pkt_start_next = 1'b1;
         pkt_index_next = '0;
         sent_next      = sent + 5'd1;
         if (ptr_take) rr_ptr_next = pick_idx;
      end
   end

   // Mode is derived from the next state so it flips on the same edge as grant and pkt_index.
   always_comb begin
      mode_next = 2'b00;
      case (state_next)
         S_PREAMBLE:                  mode_next = 2'b01;
         S_LEAD_GUARD, S_TRAIL_GUARD: mode_next = 2'b10;
         S_PACKET:                    mode_next = 2'b11;
         default:                     mode_next = 2'b00;
      endcase
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         phase       <= '0;
         rr_ptr      <= PTR_W'(NUM_SOURCES - 1);
         sent        <= '0;
         gap         <= GAP_DONE;
         grant_q     <= '0;
         pkt_start_q <= 1'b0;
         pkt_index_q <= '0;
         mode_q      <= 2'b00;
         active_q    <= 1'b0;
      end else begin
         state       <= state_next;
         phase       <= phase_next;
         rr_ptr      <= rr_ptr_next;
         sent        <= sent_next;
         gap         <= gap_next;
         grant_q     <= grant_next;
         pkt_start_q <= pkt_start_next;
         pkt_index_q <= pkt_index_next;
         mode_q      <= mode_next;
         active_q    <= (mode_next != 2'b00);
      end
   end

   assign bus.grant         = grant_q;
   assign bus.pkt_start     = pkt_start_q;
   assign bus.pkt_index     = pkt_index_q;
   assign bus.mode          = mode_q;
   assign bus.island_active = active_q;
endmodule
